// File: rtl/fast_pkg.sv
// Shared types for the FAST window fetch path.
// Direction codes follow pixel_pos; bit 1 alone selects a downward move.
package fast_pkg;

  localparam int WIN_DEFAULT = 7;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10
  } dir_t;

  function automatic dir_t dir_decode(input logic [1:0] d);
    if (d[1]) return DIR_DOWN;
    if (d[0]) return DIR_LEFT;
    return DIR_RIGHT;
  endfunction

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_IDLE    = 3'd0;
  localparam fetch_state_t S_INIT    = 3'd1;
  localparam fetch_state_t S_FILL    = 3'd2;
  localparam fetch_state_t S_WAIT    = 3'd3;
  localparam fetch_state_t S_PRESENT = 3'd4;
  localparam fetch_state_t S_UPDATE  = 3'd5;
  localparam fetch_state_t S_STEP    = 3'd6;
  localparam fetch_state_t S_DONE    = 3'd7;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_LEFT  = 2'd1;
  localparam logic [1:0] OP_RIGHT = 2'd2;
  localparam logic [1:0] OP_UP    = 2'd3;

endpackage

// File: rtl/fast_window_fetch_shift.sv
// WIN x WIN pixel register array for the FAST neighbourhood.
// A shift and a single-slot write may land in the same cycle.
module window_shift_reg
  import fast_pkg::*;
#(
  parameter int WIN   = WIN_DEFAULT,
  parameter int PIX_W = 8,
  localparam int CW   = $clog2(WIN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               op,
  input  logic                     wr_en,
  input  logic [CW-1:0]            wr_r,
  input  logic [CW-1:0]            wr_c,
  input  logic [PIX_W-1:0]         wr_data,
  output logic [WIN*WIN*PIX_W-1:0] window
);

  localparam int N  = WIN * WIN;
  localparam int IW = $clog2(N);

  logic [PIX_W-1:0] mem [N];
  logic [PIX_W-1:0] nxt [N];
  logic [IW-1:0]    wr_idx;

  assign wr_idx = IW'(wr_r) * IW'(WIN) + IW'(wr_c);

  always_comb begin
    nxt = mem;
    case (op)
      OP_LEFT:
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN - 1; c++)
            nxt[r*WIN+c] = mem[r*WIN+c+1];
      OP_RIGHT:
        for (int r = 0; r < WIN; r++)
          for (int c = 1; c < WIN; c++)
            nxt[r*WIN+c] = mem[r*WIN+c-1];
      OP_UP:
        for (int r = 0; r < WIN - 1; r++)
          for (int c = 0; c < WIN; c++)
            nxt[r*WIN+c] = mem[(r+1)*WIN+c];
      default: ;
    endcase
    if (wr_en) nxt[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      mem <= nxt;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign window[g*PIX_W +: PIX_W] = mem[g];
  end

endmodule

// File: rtl/fast_window_fetch.sv
// Snake-order window fetcher for the FAST scorer.
// Full fill once per frame, then one new row/column per move.
module fast_window_fetch
  import fast_pkg::*;
#(
  parameter int X_MAX = 300,
  parameter int Y_MAX = 300,
  parameter int WIN   = WIN_DEFAULT,
  parameter int PIX_W = 8,
  localparam int XW   = $clog2(X_MAX),
  localparam int YW   = $clog2(Y_MAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [XW-1:0]            img_w,
  input  logic [YW-1:0]            img_h,
  output logic                     new_trans,
  output logic                     update_pos,
  output logic [XW-1:0]            max_x,
  output logic [YW-1:0]            max_y,
  input  logic [XW-1:0]            curr_x,
  input  logic [YW-1:0]            curr_y,
  input  logic [1:0]               next_dir,
  input  logic                     end_pos,
  output logic                     rd_en,
  output logic [XW-1:0]            rd_x,
  output logic [YW-1:0]            rd_y,
  input  logic [PIX_W-1:0]         rd_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [WIN*WIN*PIX_W-1:0] window,
  output logic                     done
);

  localparam int CW = $clog2(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  fetch_state_t  state;
  dir_t          dir_q;
  logic [CW-1:0] r_cnt, c_cnt;
  logic [CW-1:0] rd_r, rd_c;
  logic [CW-1:0] cap_r, cap_c;
  logic [1:0]    rd_op, cap_op;
  logic          cap_en;
  logic          is_fill, is_step;
  logic          step_first, step_last;

  assign is_fill    = (state == S_FILL);
  assign is_step    = (state == S_STEP);
  assign step_first = is_step && (r_cnt == '0) && (c_cnt == '0);
  assign step_last  = (dir_q == DIR_DOWN) ? (c_cnt == LAST)
                                          : (r_cnt == LAST);

  assign new_trans  = (state == S_INIT);
  assign update_pos = (state == S_UPDATE);
  assign win_valid  = (state == S_PRESENT);
  assign done       = (state == S_DONE);
  assign rd_en      = is_fill || is_step;

  always_comb begin
    rd_x  = '0;
    rd_y  = '0;
    rd_r  = r_cnt;
    rd_c  = c_cnt;
    rd_op = OP_NONE;
    if (is_fill) begin
      rd_x = curr_x + XW'(c_cnt);
      rd_y = curr_y + YW'(r_cnt);
    end else if (is_step) begin
      case (dir_q)
        DIR_RIGHT: begin
          rd_x  = curr_x + XW'(LAST);
          rd_y  = curr_y + YW'(r_cnt);
          rd_c  = LAST;
          rd_op = OP_LEFT;
        end
        DIR_LEFT: begin
          rd_x  = curr_x;
          rd_y  = curr_y + YW'(r_cnt);
          rd_c  = '0;
          rd_op = OP_RIGHT;
        end
        default: begin
          rd_x  = curr_x + XW'(c_cnt);
          rd_y  = curr_y + YW'(LAST);
          rd_r  = LAST;
          rd_op = OP_UP;
        end
      endcase
    end
  end

  // RAM latency: slot and shift travel one cycle behind the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_en <= 1'b0;
      cap_r  <= '0;
      cap_c  <= '0;
      cap_op <= OP_NONE;
    end else begin
      cap_en <= rd_en;
      cap_r  <= rd_r;
      cap_c  <= rd_c;
      cap_op <= step_first ? rd_op : OP_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      dir_q <= DIR_RIGHT;
      r_cnt <= '0;
      c_cnt <= '0;
      max_x <= '0;
      max_y <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          max_x <= img_w - XW'(WIN);
          max_y <= img_h - YW'(WIN);
          state <= S_INIT;
        end
        S_INIT: begin
          r_cnt <= '0;
          c_cnt <= '0;
          state <= S_FILL;
        end
        S_FILL: begin
          if (c_cnt == LAST) begin
            c_cnt <= '0;
            if (r_cnt == LAST) state <= S_WAIT;
            else r_cnt <= r_cnt + 1'b1;
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        S_WAIT: state <= S_PRESENT;
        S_PRESENT: if (win_ready) begin
          if (end_pos) begin
            state <= S_DONE;
          end else begin
            dir_q <= dir_decode(next_dir);
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_cnt <= '0;
          c_cnt <= '0;
          state <= S_STEP;
        end
        S_STEP: begin
          if (dir_q == DIR_DOWN) c_cnt <= c_cnt + 1'b1;
          else r_cnt <= r_cnt + 1'b1;
          if (step_last) state <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  window_shift_reg #(
    .WIN   (WIN),
    .PIX_W (PIX_W)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .op      (cap_op),
    .wr_en   (cap_en),
    .wr_r    (cap_r),
    .wr_c    (cap_c),
    .wr_data (rd_data),
    .window  (window)
  );

endmodule

// File: tb/tb_fast_window_fetch.sv
// Bench for fast_window_fetch: snake position model, RAM model,
// per-cycle window comparison and per-frame timing checks.
module tb_fast_window_fetch;

  localparam int WIN   = 7;
  localparam int PIX_W = 8;
  localparam int XW    = 9;
  localparam int YW    = 9;
  localparam int WB    = WIN * WIN * PIX_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] img_w;
  logic [YW-1:0] img_h;
  logic          new_trans, update_pos;
  logic [XW-1:0] max_x;
  logic [YW-1:0] max_y;
  logic [XW-1:0] curr_x;
  logic [YW-1:0] curr_y;
  logic [1:0]    next_dir;
  logic          end_pos;
  logic          rd_en;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [7:0]    rd_data;
  logic          win_valid, win_ready, done;
  logic [WB-1:0] window;

  int passed = 0;
  int total  = 0;
  int cx = 0, cy = 0, mx = 0, my = 0;
  int cur_w = 8, cur_h = 8;

  fast_window_fetch #(
    .X_MAX (300),
    .Y_MAX (300),
    .WIN   (WIN),
    .PIX_W (PIX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_w      (img_w),
    .img_h      (img_h),
    .new_trans  (new_trans),
    .update_pos (update_pos),
    .max_x      (max_x),
    .max_y      (max_y),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .next_dir   (next_dir),
    .end_pos    (end_pos),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .window     (window),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'(x + 8 * y);
  endfunction

  function automatic logic [WB-1:0] exp_win(input int x0, input int y0);
    logic [WB-1:0] v;
    v = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        v[(r*WIN+c)*PIX_W +: PIX_W] = pix(x0 + c, y0 + r);
    return v;
  endfunction

  // synchronous frame RAM
  always @(posedge clk)
    if (rd_en) rd_data <= pix(int'(rd_x), int'(rd_y));

  // pixel_pos model: boustrophedon walk over the window positions
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= 0;
      cy <= 0;
    end else if (new_trans) begin
      cx <= 0;
      cy <= 0;
    end else if (update_pos) begin
      if (cy % 2 == 0 && cx < mx) cx <= cx + 1;
      else if (cy % 2 == 1 && cx > 0) cx <= cx - 1;
      else cy <= cy + 1;
    end
  end

  always_comb begin
    curr_x   = XW'(cx);
    curr_y   = YW'(cy);
    next_dir = (cy % 2 == 1) ? 2'b11 : 2'b10;
    if (cy % 2 == 0 && cx < mx) next_dir = 2'b00;
    if (cy % 2 == 1 && cx > 0) next_dir = 2'b01;
    end_pos = (cy == my) && ((cy % 2 == 0) ? (cx == mx) : (cx == 0));
  end

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  function automatic bit all_zero();
    return !(new_trans | update_pos | rd_en | win_valid | done) &&
           max_x == '0 && max_y == '0 && rd_x == '0 && rd_y == '0 &&
           window == '0;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid) begin
        total++;
        if (window === exp_win(cx, cy)) passed++;
        else $display("FAIL window at (%0d,%0d): got %h want %h",
                      cx, cy, window, exp_win(cx, cy));
        chk(!rd_en && !update_pos, "present_quiet",
            {rd_en, update_pos}, 0);
      end
      if (rd_en)
        chk(int'(rd_x) < cur_w && int'(rd_y) < cur_h, "rd_bounds",
            int'(rd_x) * 1000 + int'(rd_y), cur_w * 1000 + cur_h);
    end
  end

  // mode: 0 ready high, 1 random, 2 stall 20 at 2nd window,
  //       3 stall 5 at 1st window with a start pulse inside
  task automatic run_frame(input int w, input int h,
                           input int mode, input bit lit);
    int t, reads, nwin, acc_t, hold, nt, want_t;
    bit prev_v, last_acc, finished, rdy;
    logic [7:0] first0 [$];
    int lit_exp [4] = '{0, 1, 9, 8};
    cur_w = w;
    cur_h = h;
    mx = w - WIN;
    my = h - WIN;
    img_w = XW'(w);
    img_h = YW'(h);
    win_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0; reads = 0; nwin = 0; acc_t = -100; hold = 0; nt = 0;
    prev_v = 0; last_acc = 0; finished = 0;
    while (!finished && t < 5000) begin
      start = 1'b0;
      if (new_trans) begin
        nt++;
        chk(t == 0, "new_trans_time", t, 0);
      end
      if (rd_en) reads++;
      if (t == 1) chk(rd_en, "first_read", rd_en, 1);
      if (update_pos)
        chk(t == acc_t + 1 && !last_acc, "update_pos_time", t, acc_t + 1);
      if (done) begin
        chk(last_acc && t == acc_t + 1, "done_time", t, acc_t + 1);
        finished = 1;
      end
      if (win_valid && !prev_v) begin
        want_t = (nwin == 0) ? WIN * WIN + 2 : acc_t + WIN + 3;
        chk(t == want_t, "valid_latency", t, want_t);
        chk(reads == ((nwin == 0) ? WIN * WIN : WIN), "read_count",
            reads, (nwin == 0) ? WIN * WIN : WIN);
        chk(int'(max_x) == mx && int'(max_y) == my, "max_xy",
            int'(max_x) * 1000 + int'(max_y), mx * 1000 + my);
        if (lit && nwin == 0) begin
          chk(window[7:0] == 8'd0, "lit_w00", window[7:0], 0);
          chk(window[48*8 +: 8] == 8'd54, "lit_w66", window[48*8 +: 8], 54);
        end
        first0.push_back(window[7:0]);
        reads = 0;
        hold = 0;
      end
      prev_v = win_valid;
      if (win_valid) begin
        case (mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          2: rdy = !(nwin == 1 && hold < 20);
          default: rdy = (hold >= 5);
        endcase
        if (mode == 3 && hold == 2) start = 1'b1;
        hold++;
        win_ready = rdy;
        if (rdy) begin
          acc_t = t;
          last_acc = end_pos;
          nwin++;
        end
      end else begin
        win_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      t++;
    end
    win_ready = 1'b0;
    start = 1'b0;
    chk(finished, "frame_done", finished, 1);
    chk(nt == 1, "new_trans_count", nt, 1);
    chk(nwin == (mx + 1) * (my + 1), "window_count", nwin,
        (mx + 1) * (my + 1));
    chk(!done && !win_valid, "done_pulse", {done, win_valid}, 0);
    if (lit) begin
      chk(first0.size() == 4, "lit_count", first0.size(), 4);
      for (int i = 0; i < 4 && i < first0.size(); i++)
        chk(first0[i] == lit_exp[i], "lit_first_pixel",
            first0[i], lit_exp[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    img_w = '0;
    img_h = '0;
    repeat (2) begin
      @(negedge clk);
      chk(all_zero(), "reset_outputs", 0, 1);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(all_zero(), "idle_after_reset", 0, 1);
    end

    run_frame(8, 8, 0, 1);
    run_frame(8, 8, 2, 0);

    // abort during FILL
    cur_w = 8; cur_h = 8; mx = 1; my = 1;
    img_w = XW'(8);
    img_h = YW'(8);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk(rd_en, "fill_before_abort", rd_en, 1);
    rst = 1'b1;
    #1;
    chk(all_zero(), "async_abort", 0, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk(all_zero(), "no_done_after_abort", done, 0);
    end
    run_frame(8, 8, 1, 0);

    run_frame(7, 7, 3, 0);

    repeat (6)
      run_frame(int'($urandom_range(7, 13)), int'($urandom_range(7, 12)),
                1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
